// File: rtl/alu_issue_arb.sv
// Two-requester issue arbiter for a shared combinational ALU: IDLE -> EXEC -> WB per op.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties) instead of round-robin.
module alu_issue_arb #(
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [4:0]     req0_rd,
  input  logic [31:0]    req0_rs1,
  input  logic [31:0]    req0_rs2,
  input  logic [19:0]    req0_imm,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [4:0]     req1_rd,
  input  logic [31:0]    req1_rs1,
  input  logic [31:0]    req1_rs2,
  input  logic [19:0]    req1_imm,
  output logic           alu_valid,
  output logic [OPW-1:0] alu_op,
  output logic [4:0]     alu_rd,
  output logic [31:0]    alu_rs1,
  output logic [31:0]    alu_rs2,
  output logic [19:0]    alu_imm,
  input  logic [4:0]     alu_rd_out,
  input  logic           alu_out_en,
  input  logic [31:0]    alu_rd_data,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic           wb_src,
  output logic [4:0]     wb_rd,
  output logic [31:0]    wb_data,
  output logic           wb_err
);

  // state | meaning
  // IDLE  | waiting for a request; ready offered to the arbitration winner
  // EXEC  | latched operands presented to the ALU for one cycle
  // WB    | ALU result held on wb_* until wb_ready
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t         state, state_nxt;
  logic           win;
  logic           hs;
  logic           src_q;
  logic [OPW-1:0] op_q;
  logic [4:0]     rd_q;
  logic [31:0]    rs1_q, rs2_q;
  logic [19:0]    imm_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    win = ~req0_valid;
  end
`else
  logic last_gnt;

  always_comb begin
    if (req0_valid && req1_valid) win = ~last_gnt;
    else                          win = ~req0_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     last_gnt <= 1'b1;
    else if (hs) last_gnt <= win;
  end
`endif

  // Ready is held low while reset is asserted so no handshake can be seen during reset.
  assign hs         = (state == IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = hs && !win;
  assign req1_ready = hs && win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_valid = 1'b0;
    alu_op    = '0;
    alu_rd    = '0;
    alu_rs1   = '0;
    alu_rs2   = '0;
    alu_imm   = '0;
    wb_valid  = 1'b0;
    case (state)
      EXEC: begin
        alu_valid = 1'b1;
        alu_op    = op_q;
        alu_rd    = rd_q;
        alu_rs1   = rs1_q;
        alu_rs2   = rs2_q;
        alu_imm   = imm_q;
      end
      WB:      wb_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= 1'b0;
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (hs) begin
      src_q <= win;
      op_q  <= win ? req1_op  : req0_op;
      rd_q  <= win ? req1_rd  : req0_rd;
      rs1_q <= win ? req1_rs1 : req0_rs1;
      rs2_q <= win ? req1_rs2 : req0_rs2;
      imm_q <= win ? req1_imm : req0_imm;
    end
  end

  // Writes to x0 or from a disabled ALU result carry no data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_src  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_err  <= 1'b0;
    end else if (state == EXEC) begin
      wb_src  <= src_q;
      wb_rd   <= alu_rd_out;
      wb_data <= (alu_out_en && (alu_rd_out != 5'd0)) ? alu_rd_data : 32'd0;
      wb_err  <= ~alu_out_en;
    end
  end

endmodule
